rvfi_bus_responder: RTL and testbench

Parametrised, in-order memory-bus responder model for formal and simulation environments around the RV core. One instance serves one request/response channel (instruction fetch or data). It turns free random inputs into a legal slave: it bounds outstanding requests to DEPTH, returns responses in request order with echoed metadata, and flags master protocol violations. Optional fairness bounds every stall to MAX_STALL cycles.

---
 rtl/rvfi_bus_responder_if.sv | 26 ++
 rtl/rvfi_bus_responder.sv | 131 +++++++++++++
 tb/tb_rvfi_bus_responder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rvfi_bus_responder_if.sv
// Request/response channel between an RV core memory port and its bus responder model.
interface rvfi_bus_responder_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic [ADDR_W-1:0] rsp_addr;
   logic              rsp_wr;

   modport master (
      output req_valid, req_wr, req_addr, req_size, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_addr, rsp_wr
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_size, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_addr, rsp_wr
   );
endinterface

// File: rtl/rvfi_bus_responder.sv
// In-order bus responder driven by free random inputs; bounds outstanding requests and flags
// master protocol violations. Define RVFI_BUS_FAIRNESS_EN to force progress after MAX_STALL.
module rvfi_bus_responder #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MAX_STALL = 3,
   parameter int unsigned WRITE_RSP = 0
) (
   input  logic                           clock,
   input  logic                           reset,
   rvfi_bus_responder_if.slave            bus,
   input  logic                           rnd_ready_i,
   input  logic                           rnd_rsp_i,
   input  logic [DATA_W-1:0]              rnd_data_i,
   output logic [$clog2(DEPTH+1)-1:0]     outstanding_o,
   output logic [$clog2(MAX_STALL+1)-1:0] req_stall_cnt_o,
   output logic [$clog2(MAX_STALL+1)-1:0] rsp_stall_cnt_o,
   output logic                           proto_err_o
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(MAX_STALL + 1);
   localparam logic [SW-1:0] StallMax = SW'(MAX_STALL);
   localparam logic [CW-1:0] CntFull  = CW'(DEPTH);

   logic [ADDR_W:0]   mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [SW-1:0]     req_stall_q, req_stall_d;
   logic [SW-1:0]     rsp_stall_q, rsp_stall_d;
   logic              perr_q, perr_d;
   logic              stalled_q;
   logic              prev_wr_q;
   logic [ADDR_W-1:0] prev_addr_q;
   logic [1:0]        prev_size_q;
   logic [DATA_W-1:0] prev_wdata_q;

   logic              full, empty, req_gate, rsp_gate;
   logic              accept, push, pop, proto_hit;
   logic [ADDR_W:0]   head;

   assign full  = (cnt_q == CntFull);
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_ptr_q];

`ifdef RVFI_BUS_FAIRNESS_EN
   assign req_gate = rnd_ready_i || (req_stall_q == StallMax);
   assign rsp_gate = rnd_rsp_i || (rsp_stall_q == StallMax);
`else
   assign req_gate = rnd_ready_i;
   assign rsp_gate = rnd_rsp_i;
`endif

   assign bus.req_ready = !reset && bus.req_valid && !full && req_gate;
   assign bus.rsp_valid = !reset && !empty && rsp_gate;
   assign bus.rsp_addr  = bus.rsp_valid ? head[ADDR_W-1:0] : '0;
   assign bus.rsp_wr    = bus.rsp_valid && head[ADDR_W];
   assign bus.rsp_rdata = (bus.rsp_valid && !head[ADDR_W]) ? rnd_data_i : '0;

   assign accept = bus.req_valid && bus.req_ready;
   // Posted writes are acknowledged but never answered, so they take no queue slot.
   assign push   = accept && (!bus.req_wr || (WRITE_RSP != 0));
   assign pop    = bus.rsp_valid;

   // A stalled request must hold steady; write data only matters for writes.
   assign proto_hit = stalled_q &&
                      (!bus.req_valid || (bus.req_wr != prev_wr_q) ||
                       (bus.req_addr != prev_addr_q) || (bus.req_size != prev_size_q) ||
                       (prev_wr_q && (bus.req_wdata != prev_wdata_q)));

   always_comb begin
      wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      cnt_d       = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!push && pop) begin
         cnt_d = cnt_q - CW'(1);
      end
      req_stall_d = '0;
      if (bus.req_valid && !bus.req_ready) begin
         req_stall_d = (req_stall_q == StallMax) ? StallMax : req_stall_q + SW'(1);
      end
      rsp_stall_d = '0;
      if (!empty && !bus.rsp_valid) begin
         rsp_stall_d = (rsp_stall_q == StallMax) ? StallMax : rsp_stall_q + SW'(1);
      end
      perr_d      = perr_q || proto_hit;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         req_stall_q  <= '0;
         rsp_stall_q  <= '0;
         perr_q       <= 1'b0;
         stalled_q    <= 1'b0;
         prev_wr_q    <= 1'b0;
         prev_addr_q  <= '0;
         prev_size_q  <= '0;
         prev_wdata_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         req_stall_q  <= req_stall_d;
         rsp_stall_q  <= rsp_stall_d;
         perr_q       <= perr_d;
         stalled_q    <= bus.req_valid && !bus.req_ready;
         prev_wr_q    <= bus.req_wr;
         prev_addr_q  <= bus.req_addr;
         prev_size_q  <= bus.req_size;
         prev_wdata_q <= bus.req_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {bus.req_wr, bus.req_addr};
      end
   end

   assign outstanding_o   = cnt_q;
   assign req_stall_cnt_o = req_stall_q;
   assign rsp_stall_cnt_o = rsp_stall_q;
   assign proto_err_o     = perr_q;
endmodule

// File: tb/tb_rvfi_bus_responder.sv
// Randomized bench for rvfi_bus_responder: a posted-write and a write-response instance share
// stimulus and are checked every cycle against a queue-based reference model.
module tb_rvfi_bus_responder;
   localparam int unsigned Dep  = 4;
   localparam int unsigned MaxS = 3;
`ifdef RVFI_BUS_FAIRNESS_EN
   localparam bit Fair = 1'b1;
`else
   localparam bit Fair = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        valid = 1'b0, wr = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [1:0]  size = '0;
   logic        rnd_ready = 1'b0, rnd_rsp = 1'b0;
   logic [31:0] rnd_data = '0;

   logic [2:0]  out0, out1;
   logic [1:0]  rqs0, rqs1, rss0, rss1;
   logic        perr0, perr1;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   rvfi_bus_responder_if bus0 ();
   rvfi_bus_responder_if bus1 ();

   assign bus0.req_valid = valid;
   assign bus0.req_wr    = wr;
   assign bus0.req_addr  = addr;
   assign bus0.req_size  = size;
   assign bus0.req_wdata = wdata;
   assign bus1.req_valid = valid;
   assign bus1.req_wr    = wr;
   assign bus1.req_addr  = addr;
   assign bus1.req_size  = size;
   assign bus1.req_wdata = wdata;

   rvfi_bus_responder #(.WRITE_RSP(0)) dut0 (
      .clock(clock), .reset(reset), .bus(bus0.slave),
      .rnd_ready_i(rnd_ready), .rnd_rsp_i(rnd_rsp), .rnd_data_i(rnd_data),
      .outstanding_o(out0), .req_stall_cnt_o(rqs0), .rsp_stall_cnt_o(rss0), .proto_err_o(perr0)
   );

   rvfi_bus_responder #(.WRITE_RSP(1)) dut1 (
      .clock(clock), .reset(reset), .bus(bus1.slave),
      .rnd_ready_i(rnd_ready), .rnd_rsp_i(rnd_rsp), .rnd_data_i(rnd_data),
      .outstanding_o(out1), .req_stall_cnt_o(rqs1), .rsp_stall_cnt_o(rss1), .proto_err_o(perr1)
   );

   // Reference model: one queue of {wr, addr} per instance plus plain counters.
   logic [32:0] q0[$];
   logic [32:0] q1[$];
   int          m_rqs[2] = '{0, 0};
   int          m_rss[2] = '{0, 0};
   bit          m_perr[2] = '{0, 0};
   bit          m_stalled[2] = '{0, 0};
   logic        p_wr = 1'b0;
   logic [31:0] p_addr = '0, p_wdata = '0;
   logic [1:0]  p_size = '0;

   task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL inst%0d %s at %0t: got %0h expected %0h", k, nm, $time, act, exp);
      end
   endtask

   task automatic model_cycle(input int k);
      int          qs;
      logic [32:0] head;
      bit          e_ready, e_rsp, e_wr;
      logic [31:0] e_addr, e_rdata;
      qs   = (k == 0) ? q0.size() : q1.size();
      head = '0;
      if (qs > 0) head = (k == 0) ? q0[0] : q1[0];
      e_ready = !reset && valid && (qs < Dep) && (rnd_ready || (Fair && m_rqs[k] == MaxS));
      e_rsp   = !reset && (qs > 0) && (rnd_rsp || (Fair && m_rss[k] == MaxS));
      e_addr  = e_rsp ? head[31:0] : 32'h0;
      e_wr    = e_rsp && head[32];
      e_rdata = (e_rsp && !head[32]) ? rnd_data : 32'h0;

      chk(k, "req_ready", (k == 0) ? bus0.req_ready : bus1.req_ready, e_ready);
      chk(k, "rsp_valid", (k == 0) ? bus0.rsp_valid : bus1.rsp_valid, e_rsp);
      chk(k, "rsp_addr", (k == 0) ? bus0.rsp_addr : bus1.rsp_addr, e_addr);
      chk(k, "rsp_wr", (k == 0) ? bus0.rsp_wr : bus1.rsp_wr, e_wr);
      chk(k, "rsp_rdata", (k == 0) ? bus0.rsp_rdata : bus1.rsp_rdata, e_rdata);
      chk(k, "outstanding", (k == 0) ? out0 : out1, qs);
      chk(k, "req_stall_cnt", (k == 0) ? rqs0 : rqs1, m_rqs[k]);
      chk(k, "rsp_stall_cnt", (k == 0) ? rss0 : rss1, m_rss[k]);
      chk(k, "proto_err", (k == 0) ? perr0 : perr1, m_perr[k]);

      if (reset) begin
         if (k == 0) q0.delete(); else q1.delete();
         m_rqs[k] = 0; m_rss[k] = 0; m_perr[k] = 0; m_stalled[k] = 0;
      end else begin
         if (m_stalled[k] && (!valid || wr != p_wr || addr != p_addr || size != p_size ||
                              (p_wr && wdata != p_wdata)))
            m_perr[k] = 1;
         if (e_rsp) begin
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         end
         if (e_ready && (!wr || k == 1)) begin
            if (k == 0) q0.push_back({wr, addr}); else q1.push_back({wr, addr});
         end
         m_rqs[k]     = (valid && !e_ready) ? ((m_rqs[k] < MaxS) ? m_rqs[k] + 1 : MaxS) : 0;
         m_rss[k]     = ((qs > 0) && !e_rsp) ? ((m_rss[k] < MaxS) ? m_rss[k] + 1 : MaxS) : 0;
         m_stalled[k] = valid && !e_ready;
      end
   endtask

   // Applies one cycle of stimulus just after the clock edge, then checks the settled outputs.
   task automatic cyc(input bit r, input bit v, input bit w, input logic [31:0] a,
                      input logic [1:0] sz, input logic [31:0] wd, input bit rr, input bit rs);
      @(posedge clock);
      #1;
      reset = r; valid = v; wr = w; addr = a; size = sz; wdata = wd;
      rnd_ready = rr; rnd_rsp = rs; rnd_data = $urandom();
      #1;
      model_cycle(0);
      model_cycle(1);
      p_wr = wr; p_addr = addr; p_size = size; p_wdata = wdata;
   endtask

   task automatic do_reset();
      cyc(1, 1, 0, 32'h0, 2'd2, 32'h0, 1, 1);
      chk(0, "lit_reset_ready", bus0.req_ready, 1'b0);
      cyc(1, 0, 0, 32'h0, 2'd2, 32'h0, 0, 0);
   endtask

   initial begin
      int acc_at, rsp_at;
      bit pr_hold;
      int pr, ps;
      logic v, w;
      logic [31:0] a, wd;
      logic [1:0] sz;

      do_reset();
      chk(0, "lit_reset_outstanding", out0, 0);
      chk(0, "lit_reset_proto", perr0, 0);

      // Back-to-back reads
      cyc(0, 1, 0, 32'h100, 2'd2, 32'h0, 1, 1);
      chk(0, "lit_b2b_ready", bus0.req_ready, 1'b1);
      chk(0, "lit_b2b_no_rsp", bus0.rsp_valid, 1'b0);
      cyc(0, 1, 0, 32'h104, 2'd2, 32'h0, 1, 1);
      chk(0, "lit_b2b_rsp1_valid", bus0.rsp_valid, 1'b1);
      chk(0, "lit_b2b_rsp1_addr", bus0.rsp_addr, 32'h100);
      chk(0, "lit_b2b_rsp1_data", bus0.rsp_rdata, rnd_data);
      chk(0, "lit_b2b_out", out0, 1);
      cyc(0, 0, 0, 32'h0, 2'd2, 32'h0, 1, 1);
      chk(0, "lit_b2b_rsp2_addr", bus0.rsp_addr, 32'h104);
      cyc(0, 0, 0, 32'h0, 2'd2, 32'h0, 1, 1);
      chk(0, "lit_b2b_drained", out0, 0);

      // Fill, then stream with simultaneous push/pop across the pointer wrap
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 32'h300 + 32'(4 * i), 2'd2, 32'h0, 1, 0);
      cyc(0, 1, 0, 32'h310, 2'd2, 32'h0, 1, 0);
      chk(0, "lit_fill_out", out0, 4);
      chk(0, "lit_fill_ready", bus0.req_ready, 1'b0);
      cyc(0, 1, 0, 32'h310, 2'd2, 32'h0, 1, 1);
      if (!Fair) chk(0, "lit_wrap_head0", bus0.rsp_addr, 32'h300);
      cyc(0, 1, 0, 32'h310, 2'd2, 32'h0, 1, 1);
      if (!Fair) chk(0, "lit_wrap_head1", bus0.rsp_addr, 32'h304);
      for (int j = 0; j < 6; j++) begin
         cyc(0, 1, 0, 32'h314 + 32'(4 * j), 2'd2, 32'h0, 1, 1);
         if (!Fair) chk(0, "lit_wrap_order", bus0.rsp_addr, 32'h308 + 32'(4 * j));
      end
      for (int j = 0; j < 8; j++) cyc(0, 0, 0, 32'h0, 2'd2, 32'h0, 1, 1);

      // Posted write versus answered write
      cyc(0, 1, 1, 32'h200, 2'd2, 32'hcafe_f00d, 1, 1);
      chk(0, "lit_wr_ready0", bus0.req_ready, 1'b1);
      chk(1, "lit_wr_ready1", bus1.req_ready, 1'b1);
      cyc(0, 0, 0, 32'h0, 2'd2, 32'h0, 1, 1);
      chk(0, "lit_posted_out", out0, 0);
      chk(0, "lit_posted_no_rsp", bus0.rsp_valid, 1'b0);
      chk(1, "lit_wrsp_valid", bus1.rsp_valid, 1'b1);
      chk(1, "lit_wrsp_wr", bus1.rsp_wr, 1'b1);
      chk(1, "lit_wrsp_rdata", bus1.rsp_rdata, 32'h0);
      chk(1, "lit_wrsp_addr", bus1.rsp_addr, 32'h200);
      cyc(0, 0, 0, 32'h0, 2'd2, 32'h0, 1, 1);

      // Address changes while stalled
      cyc(0, 1, 0, 32'h10, 2'd2, 32'h0, 0, 0);
      chk(0, "lit_proto_stall", bus0.req_ready, 1'b0);
      cyc(0, 1, 0, 32'h14, 2'd2, 32'h0, 0, 0);
      chk(0, "lit_proto_not_yet", perr0, 1'b0);
      cyc(0, 0, 0, 32'h0, 2'd2, 32'h0, 0, 0);
      chk(0, "lit_proto_set", perr0, 1'b1);
      for (int j = 0; j < 3; j++) cyc(0, 0, 0, 32'h0, 2'd2, 32'h0, 1, 1);
      chk(0, "lit_proto_sticky", perr0, 1'b1);
      do_reset();
      chk(0, "lit_proto_cleared", perr0, 1'b0);

      // Fairness: nothing random lets the read through
      acc_at = -1;
      rsp_at = -1;
      for (int i = 0; i < 12; i++) begin
         cyc(0, acc_at < 0, 0, 32'h40, 2'd2, 32'h0, 0, 0);
         if (acc_at < 0 && bus0.req_ready) acc_at = i;
         if (rsp_at < 0 && bus0.rsp_valid) rsp_at = i;
      end
      chk(0, "lit_fair_accept_cycle", acc_at, Fair ? 3 : -1);
      chk(0, "lit_fair_rsp_cycle", rsp_at, Fair ? 7 : -1);
      if (!Fair) chk(0, "lit_nofair_stall_sat", rqs0, 3);
      do_reset();

      // Reset with three entries outstanding
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'h500 + 32'(4 * i), 2'd2, 32'h0, 1, 0);
      cyc(1, 0, 0, 32'h0, 2'd2, 32'h0, 1, 1);
      chk(0, "lit_rst_pre_out", out0, 3);
      chk(0, "lit_rst_no_rsp", bus0.rsp_valid, 1'b0);
      cyc(0, 0, 0, 32'h0, 2'd2, 32'h0, 1, 1);
      chk(0, "lit_rst_post_out", out0, 0);
      chk(0, "lit_rst_no_stale", bus0.rsp_valid, 1'b0);

      // Random traffic; a stalled master usually holds its request steady
      pr = 2; ps = 2;
      v = 0; w = 0; a = '0; sz = '0; wd = '0;
      for (int i = 0; i < 2000; i++) begin
         if (i % 250 == 0) begin
            pr = $urandom_range(1, 4);
            ps = $urandom_range(0, 4);
         end
         pr_hold = (m_stalled[0] || m_stalled[1]) && ($urandom_range(0, 39) != 0);
         if (!pr_hold) begin
            v  = ($urandom_range(0, 3) != 0);
            w  = $urandom_range(0, 1) == 1;
            a  = $urandom();
            sz = 2'($urandom_range(0, 3));
            wd = $urandom();
         end
         cyc($urandom_range(0, 149) == 0, v, w, a, sz, wd,
             $urandom_range(0, 3) < pr, $urandom_range(0, 3) < ps);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end
endmodule
